// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: command codes,
// FSM states and the per-iteration datapath mode.
package muldiv_pkg;

   localparam int MULDIV_OP_WIDTH = 3;

   typedef enum logic [MULDIV_OP_WIDTH-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } muldiv_mode_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer datapath.
// Multiply: acc = {partial_hi, multiplier_remaining}; add-shift right.
// Divide:   acc = {remainder, dividend_remaining}; restoring shift-subtract.
// For divide the new quotient bit is returned on q_bit and acc_next[0] is 0;
// the caller merges the two.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  muldiv_mode_e         mode,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic                 q_bit
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH-1:0] diff_s;

   // Single add-shift or shift-subtract step selected by mode
   always_comb begin
      sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      shifted_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      // Only used when shifted_s >= operand, so the low WIDTH bits are exact.
      diff_s    = shifted_s[WIDTH-1:0] - operand;
      q_bit     = 1'b0;
      acc_next  = acc;
      if (mode == MODE_DIV) begin
         if (shifted_s >= {1'b0, operand}) begin
            q_bit    = 1'b1;
            acc_next = {diff_s, acc[WIDTH-2:0], 1'b0};
         end else begin
            q_bit    = 1'b0;
            acc_next = {shifted_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum_s, acc[WIDTH-1:1]};
      end
   end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Operands are reduced to magnitudes at issue, 32 unsigned iterations run,
// then a single FIX cycle applies sign correction and writes HI/LO.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [MULDIV_OP_WIDTH-1:0] op,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       cancel,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           hi,
   output logic [WIDTH-1:0]           lo
);

   muldiv_state_e      state_r, state_nxt_s;
   muldiv_mode_e       mode_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opnd_r;
   logic               neg_q_r;   // negate product / quotient
   logic               neg_r_r;   // negate remainder (dividend sign)
   logic               dz_r;      // divisor was zero

   logic               is_md_s, is_div_s, is_signed_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic [2*WIDTH-1:0] acc_nxt_s, acc_upd_s;
   logic               q_bit_s;
   logic [WIDTH-1:0]   res_hi_s, res_lo_s;
   logic               last_iter_s;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode     (mode_r),
      .acc      (acc_r),
      .operand  (opnd_r),
      .acc_next (acc_nxt_s),
      .q_bit    (q_bit_s)
   );

   assign busy        = (state_r != ST_IDLE);
   assign last_iter_s = (cnt_r == CNT_W'(WIDTH-1));

   // Command decode and operand magnitudes for the issue cycle
   always_comb begin
      is_md_s     = 1'b0;
      is_div_s    = 1'b0;
      is_signed_s = 1'b0;
      case (op)
         OP_MULT:  begin is_md_s = 1'b1; is_signed_s = 1'b1; end
         OP_MULTU: begin is_md_s = 1'b1; end
         OP_DIV:   begin is_md_s = 1'b1; is_div_s = 1'b1; is_signed_s = 1'b1; end
         OP_DIVU:  begin is_md_s = 1'b1; is_div_s = 1'b1; end
         default:  begin is_md_s = 1'b0; end
      endcase
      if (is_signed_s && a[WIDTH-1]) begin
         a_mag_s = -a;
      end else begin
         a_mag_s = a;
      end
      if (is_signed_s && b[WIDTH-1]) begin
         b_mag_s = -b;
      end else begin
         b_mag_s = b;
      end
   end

   // Merge the divide quotient bit into the shifted accumulator
   always_comb begin
      if (mode_r == MODE_DIV) begin
         acc_upd_s = {acc_nxt_s[2*WIDTH-1:1], q_bit_s};
      end else begin
         acc_upd_s = acc_nxt_s;
      end
   end

   // Sign correction of the magnitude result for the FIX cycle
   always_comb begin
      res_hi_s = acc_r[2*WIDTH-1:WIDTH];
      res_lo_s = acc_r[WIDTH-1:0];
      if (mode_r == MODE_DIV) begin
         if (neg_r_r) begin
            res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
         end else begin
            res_hi_s = acc_r[2*WIDTH-1:WIDTH];
         end
         if (dz_r) begin
            res_lo_s = {WIDTH{1'b1}};
         end else if (neg_q_r) begin
            res_lo_s = -acc_r[WIDTH-1:0];
         end else begin
            res_lo_s = acc_r[WIDTH-1:0];
         end
      end else begin
         if (neg_q_r) begin
            {res_hi_s, res_lo_s} = -acc_r;
         end else begin
            {res_hi_s, res_lo_s} = acc_r;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: cancel always returns to IDLE and blocks new issue
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !cancel && is_md_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cancel) begin
               state_nxt_s = ST_IDLE;
            end else if (last_iter_s) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_FIX:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath registers, HI/LO and the done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r  <= MODE_MUL;
         cnt_r   <= {CNT_W{1'b0}};
         acc_r   <= {(2*WIDTH){1'b0}};
         opnd_r  <= {WIDTH{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         dz_r    <= 1'b0;
         hi      <= {WIDTH{1'b0}};
         lo      <= {WIDTH{1'b0}};
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start && !cancel) begin
                  if (op == OP_MTHI) begin
                     hi <= a;
                  end else if (op == OP_MTLO) begin
                     lo <= a;
                  end else if (is_md_s) begin
                     cnt_r   <= {CNT_W{1'b0}};
                     neg_q_r <= is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                     if (is_div_s) begin
                        mode_r  <= MODE_DIV;
                        acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                        opnd_r  <= b_mag_s;
                        neg_r_r <= is_signed_s & a[WIDTH-1];
                        dz_r    <= (b == {WIDTH{1'b0}});
                     end else begin
                        mode_r  <= MODE_MUL;
                        acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
                        opnd_r  <= a_mag_s;
                        neg_r_r <= 1'b0;
                        dz_r    <= 1'b0;
                     end
                  end
               end
            end
            ST_RUN: begin
               if (!cancel) begin
                  acc_r <= acc_upd_s;
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_FIX: begin
               if (!cancel) begin
                  hi   <= res_hi_s;
                  lo   <= res_lo_s;
                  done <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle
// corner sequences (cancel, reset, MTHI/MTLO) and randomized ops checked
// against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        cancel;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] model_hi, model_lo;

   muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          hold;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain arithmetic, returns {hi, lo}
   function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'd0: begin p = 64'(sx * sy); return p; end
         3'd1: begin p = {32'd0, x} * {32'd0, y}; return p; end
         3'd2: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            q = sx / sy; r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return {model_hi, model_lo};
      endcase
   endfunction

   // Issue one op and observe 40 cycles; sample i is taken after edge N+i-1
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hold, output int bcnt, output int dcyc, output int dcnt);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      bcnt = 0; dcyc = 0; dcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (dcyc == 0) dcyc = i;
            if (hold) start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   vec_t vecs[$];

   initial begin
      int bc, dc, dn;
      logic [63:0] exp;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      model_hi = 32'd0; model_lo = 32'd0;

      vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{3'd3, 32'd100,       32'd0,         1'b0, 32'd100,       32'hFFFF_FFFF});
      vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000});
      vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd0,         1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd16,        1'b0, 32'h0000_000F, 32'h0FFF_FFFF});
      vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD});

      repeat (3) @(negedge clk);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      rst = 1'b0;

      foreach (vecs[k]) begin
         run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].hold, bc, dc, dn);
         chk($sformatf("vec%0d_busy_cycles", k), 64'(bc), 64'd33);
         chk($sformatf("vec%0d_done_cycle", k), 64'(dc), 64'd34);
         chk($sformatf("vec%0d_done_count", k), 64'(dn), 64'd1);
         chk($sformatf("vec%0d_hi", k), {32'd0, hi}, {32'd0, vecs[k].exp_hi});
         chk($sformatf("vec%0d_lo", k), {32'd0, lo}, {32'd0, vecs[k].exp_lo});
         model_hi = vecs[k].exp_hi; model_lo = vecs[k].exp_lo;
      end

      // MTHI while idle: single-edge write, no busy, no done
      @(negedge clk);
      op = 3'd4; a = 32'h1234_5678; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
      chk("mthi_lo", {32'd0, lo}, {32'd0, model_lo});
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      chk("mthi_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      chk("mthi_done_next", {63'd0, done}, 64'd0);
      model_hi = 32'h1234_5678;

      // MULTU 5*6 cancelled in the 10th busy cycle
      @(negedge clk);
      op = 3'd1; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("cancel_busy_before", {63'd0, busy}, 64'd1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy_after", {63'd0, busy}, 64'd0);
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("cancel_no_done", 64'(dn), 64'd0);
      chk("cancel_hi", {32'd0, hi}, {32'd0, model_hi});
      chk("cancel_lo", {32'd0, lo}, {32'd0, model_lo});

      // MTLO with cancel: cancel wins
      @(negedge clk);
      op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; cancel = 1'b0;
      chk("mtlo_cancel_lo", {32'd0, lo}, {32'd0, model_lo});
      chk("mtlo_cancel_busy", {63'd0, busy}, 64'd0);

      // Randomized ops against the reference model
      for (int n = 0; n < 24; n++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: begin end
         endcase
         exp = ref_model(ro, ra, rb);
         run_op(ro, ra, rb, 1'b0, bc, dc, dn);
         chk($sformatf("rnd%0d_op%0d_done_cycle", n, ro), 64'(dc), 64'd34);
         chk($sformatf("rnd%0d_op%0d_a%0h_b%0h", n, ro, ra, rb), {hi, lo}, exp);
         model_hi = exp[63:32]; model_lo = exp[31:0];
      end

      // Asynchronous reset mid-RUN of a DIVU
      @(negedge clk);
      op = 3'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      chk("async_rst_hi", {32'd0, hi}, 64'd0);
      chk("async_rst_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_hi = 32'd0; model_lo = 32'd0;

      run_op(3'd0, 32'd2, 32'd3, 1'b0, bc, dc, dn);
      chk("post_rst_busy_cycles", 64'(bc), 64'd33);
      chk("post_rst_done_cycle", 64'(dc), 64'd34);
      chk("post_rst_hi", {32'd0, hi}, 64'd0);
      chk("post_rst_lo", {32'd0, lo}, 64'd6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_muldiv_unit
